// File: rtl/scan_chain_driver.sv
// rtl/scan_chain_driver.sv - Two-phase latch scan chain initiator with load/read word streams
module scan_chain_driver #(
  parameter int CHAIN_LEN = 256,
  parameter int WORD_W    = 16,
  parameter int PHASE_CYC = 2
) (
  input  logic              ref_clk,
  input  logic              reset_bar,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic              scan_in,
  output logic              phi,
  output logic              phi_bar,
  output logic              capture,
  output logic              update,
  input  logic              scan_out
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int PH_W  = $clog2(PHASE_CYC + 1);
  localparam int WB_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PHASE_CYC - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CHAIN_LEN);
  localparam logic [WB_W-1:0]  WB_LAST  = WB_W'(WORD_W - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CAPT,
    S_LOAD,
    S_SETUP,
    S_PHI,
    S_GAP1,
    S_PHIB,
    S_GAP2,
    S_RDWAIT,
    S_UPD,
    S_UGAP,
    S_DONE
  } state_t;

  state_t             state;
  logic [PH_W-1:0]    phase_cnt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [WB_W-1:0]    wbit;
  logic [WORD_W-1:0]  word_sr;
  logic               op_upd;
  logic               phase_last;
  logic [WORD_W-1:0]  word_next;

  assign phase_last = (phase_cnt == PH_LAST);
  assign word_next  = word_sr >> 1;

  always_ff @(posedge ref_clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      wbit      <= '0;
      word_sr   <= '0;
      op_upd    <= 1'b0;
      wr_ready  <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      scan_in   <= 1'b0;
      phi       <= 1'b0;
      phi_bar   <= 1'b0;
      capture   <= 1'b0;
      update    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            op_upd  <= op[1];
            bit_cnt <= '0;
            wbit    <= '0;
            rd_data <= '0;
            if (op[0]) begin
              capture <= 1'b1;
              state   <= S_CAPT;
            end else begin
              wr_ready <= 1'b1;
              state    <= S_LOAD;
            end
          end
        end
        // The capture pair reuses the shift phase sequence with capture held high.
        S_CAPT: begin
          phi       <= 1'b1;
          phase_cnt <= '0;
          state     <= S_PHI;
        end
        S_LOAD: begin
          if (wr_valid) begin
            wr_ready <= 1'b0;
            word_sr  <= wr_data;
            scan_in  <= wr_data[0];
            wbit     <= '0;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          phi       <= 1'b1;
          phase_cnt <= '0;
          state     <= S_PHI;
        end
        S_PHI: begin
          if (phase_last) begin
            phi       <= 1'b0;
            phase_cnt <= '0;
            state     <= S_GAP1;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        S_GAP1: begin
          if (phase_last) begin
            phi_bar   <= 1'b1;
            phase_cnt <= '0;
            state     <= S_PHIB;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        S_PHIB: begin
          if (phase_last) begin
            phi_bar   <= 1'b0;
            phase_cnt <= '0;
            state     <= S_GAP2;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        S_GAP2: begin
          if (!phase_last) begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end else begin
            phase_cnt <= '0;
            if (capture) begin
              capture  <= 1'b0;
              wr_ready <= 1'b1;
              state    <= S_LOAD;
            end else begin
              // Both latch phases have completed, so scan_out now holds this bit's read value.
              rd_data[wbit] <= scan_out;
              bit_cnt       <= bit_cnt + CNT_W'(1);
              if (bit_cnt == BIT_LAST || wbit == WB_LAST) begin
                rd_valid <= 1'b1;
                state    <= S_RDWAIT;
              end else begin
                wbit    <= wbit + WB_W'(1);
                word_sr <= word_next;
                scan_in <= word_next[0];
                state   <= S_SETUP;
              end
            end
          end
        end
        S_RDWAIT: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            if (bit_cnt == BIT_END) begin
              if (op_upd) begin
                update <= 1'b1;
                state  <= S_UPD;
              end else begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            end else begin
              wr_ready <= 1'b1;
              state    <= S_LOAD;
            end
          end
        end
        S_UPD: begin
          if (phase_last) begin
            update    <= 1'b0;
            phase_cnt <= '0;
            state     <= S_UGAP;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        S_UGAP: begin
          if (phase_last) begin
            phase_cnt <= '0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_driver.sv
// tb/tb_scan_chain_driver.sv - Directed bench with two-phase latch chain models (8-bit and 10-bit chains)
module tb_scan_chain_driver;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start_a, wr_valid_a, wr_ready_a, rd_valid_a, rd_ready_a, busy_a, done_a;
  logic       scan_in_a, phi_a, phi_bar_a, capture_a, update_a, scan_out_a;
  logic [1:0] op_a;
  logic [3:0] wr_data_a, rd_data_a;
  logic       start_b, wr_valid_b, wr_ready_b, rd_valid_b, rd_ready_b, busy_b, done_b;
  logic       scan_in_b, phi_b, phi_bar_b, capture_b, update_b, scan_out_b;
  logic [1:0] op_b;
  logic [3:0] wr_data_b, rd_data_b;

  scan_chain_driver #(.CHAIN_LEN(8), .WORD_W(4), .PHASE_CYC(1)) dut_a (
    .ref_clk(clk), .reset_bar(rst_n), .start(start_a), .op(op_a),
    .wr_data(wr_data_a), .wr_valid(wr_valid_a), .wr_ready(wr_ready_a),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_ready(rd_ready_a),
    .busy(busy_a), .done(done_a), .scan_in(scan_in_a), .phi(phi_a), .phi_bar(phi_bar_a),
    .capture(capture_a), .update(update_a), .scan_out(scan_out_a)
  );

  scan_chain_driver #(.CHAIN_LEN(10), .WORD_W(4), .PHASE_CYC(1)) dut_b (
    .ref_clk(clk), .reset_bar(rst_n), .start(start_b), .op(op_b),
    .wr_data(wr_data_b), .wr_valid(wr_valid_b), .wr_ready(wr_ready_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_ready(rd_ready_b),
    .busy(busy_b), .done(done_b), .scan_in(scan_in_b), .phi(phi_b), .phi_bar(phi_bar_b),
    .capture(capture_b), .update(update_b), .scan_out(scan_out_b)
  );

  int vectors = 0;
  int miscompares = 0;

  // Latch chain A: index 0 is nearest scan_out, with an output latch pair feeding scan_out.
  logic [7:0] s_a, m_a, upd_a, cap_src_a, pre_val_a;
  logic       mo_a, so_a, pre_a;
  assign scan_out_a = so_a;
  always @(posedge phi_a or posedge phi_bar_a or posedge update_a or posedge pre_a) begin
    if (pre_a) begin
      s_a <= pre_val_a; so_a <= 1'b0; mo_a <= 1'b0;
    end else begin
      if (phi_a) begin
        if (capture_a) m_a <= cap_src_a;
        else begin m_a <= {scan_in_a, s_a[7:1]}; mo_a <= s_a[0]; end
      end
      if (phi_bar_a) begin s_a <= m_a; if (!capture_a) so_a <= mo_a; end
      if (update_a) upd_a <= s_a;
    end
  end

  logic [9:0] s_b, m_b, pre_val_b;
  logic       mo_b, so_b, pre_b;
  assign scan_out_b = so_b;
  always @(posedge phi_b or posedge phi_bar_b or posedge pre_b) begin
    if (pre_b) begin
      s_b <= pre_val_b; so_b <= 1'b0; mo_b <= 1'b0;
    end else begin
      if (phi_b) begin m_b <= {scan_in_b, s_b[9:1]}; mo_b <= s_b[0]; end
      if (phi_bar_b) begin s_b <= m_b; so_b <= mo_b; end
    end
  end

  logic clr = 1'b0;
  logic phi_pa = 1'b0, phib_pa = 1'b0, cap_pa = 1'b0, upd_pa = 1'b0, sin_pa = 1'b0;
  int   shift_a = 0, phib_cnt_a = 0, cap_cnt_a = 0, upd_cnt_a = 0, viol_a = 0;
  logic [7:0] bits_a = '0;
  always @(negedge clk) begin
    if (clr) begin
      shift_a <= 0; phib_cnt_a <= 0; cap_cnt_a <= 0; upd_cnt_a <= 0; bits_a <= '0;
    end else begin
      if (phi_a && phi_bar_a) viol_a <= viol_a + 1;
      if ((phi_a && !phi_pa && phib_pa) || (phi_bar_a && !phib_pa && phi_pa)) viol_a <= viol_a + 1;
      if ((capture_a != cap_pa || update_a != upd_pa) && (phi_a || phi_bar_a || phi_pa || phib_pa))
        viol_a <= viol_a + 1;
      if (update_a && (phi_a || phi_bar_a || capture_a)) viol_a <= viol_a + 1;
      if ((wr_ready_a || rd_valid_a) && (phi_a || phi_bar_a)) viol_a <= viol_a + 1;
      if (scan_in_a != sin_pa && (phi_a || phi_bar_a)) viol_a <= viol_a + 1;
      if (phi_a && !phi_pa) begin
        if (capture_a) begin
          cap_cnt_a <= cap_cnt_a + 1;
          if (shift_a != 0) viol_a <= viol_a + 1;
        end else begin
          if (shift_a < 8) bits_a[shift_a] <= scan_in_a;
          shift_a <= shift_a + 1;
        end
      end
      if (phi_bar_a && !phib_pa) phib_cnt_a <= phib_cnt_a + 1;
      if (update_a && !upd_pa) begin
        upd_cnt_a <= upd_cnt_a + 1;
        if (shift_a != 8) viol_a <= viol_a + 1;
      end
    end
    phi_pa <= phi_a; phib_pa <= phi_bar_a; cap_pa <= capture_a; upd_pa <= update_a; sin_pa <= scan_in_a;
  end

  logic phi_pb = 1'b0, phib_pb = 1'b0;
  int   phi_cnt_b = 0, phib_cnt_b = 0, viol_b = 0;
  always @(negedge clk) begin
    if (clr) begin
      phi_cnt_b <= 0; phib_cnt_b <= 0;
    end else begin
      if (phi_b && phi_bar_b) viol_b <= viol_b + 1;
      if (capture_b || update_b) viol_b <= viol_b + 1;
      if (phi_b && !phi_pb) phi_cnt_b <= phi_cnt_b + 1;
      if (phi_bar_b && !phib_pb) phib_cnt_b <= phib_cnt_b + 1;
    end
    phi_pb <= phi_b; phib_pb <= phi_bar_b;
  end

  int         lat_a, lat_b, rd_n_a, rd_n_b;
  logic [3:0] rd_w_a [2];
  logic [3:0] rd_w_b [3];

  task automatic clear_mon();
    @(negedge clk); #1 clr = 1'b1;
    @(negedge clk); #1 clr = 1'b0;
  endtask

  task automatic preload_a(input logic [7:0] v);
    pre_val_a = v; pre_a = 1'b1; #1 pre_a = 1'b0;
  endtask

  task automatic preload_b(input logic [9:0] v);
    pre_val_b = v; pre_b = 1'b1; #1 pre_b = 1'b0;
  endtask

  task automatic run_a(input logic [1:0] o, input logic [3:0] w0, input logic [3:0] w1,
                       input int wr_gap, input int rd_gap, input bit poke);
    int wi, ri, ws, rs, hs, dc;
    wi = 0; ri = 0; ws = 0; rs = 0; hs = -1; dc = -1;
    @(negedge clk); start_a = 1'b1; op_a = o;
    @(negedge clk); start_a = 1'b0; op_a = ~o;
    for (int cyc = 0; cyc < 3000 && dc < 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (done_a) dc = cyc;
      if (poke && cyc == 12) begin start_a = 1'b1; op_a = 2'b11; end
      else start_a = 1'b0;
      if (wr_ready_a && wi < 2) begin
        if (wi == 1 && ws < wr_gap) begin wr_valid_a = 1'b0; ws++; end
        else begin wr_valid_a = 1'b1; wr_data_a = (wi == 0) ? w0 : w1; end
      end else wr_valid_a = 1'b0;
      if (wr_valid_a && wr_ready_a) begin if (wi == 0) hs = cyc; wi++; end
      if (rd_valid_a) begin
        if (ri == 0 && rs < rd_gap) begin rd_ready_a = 1'b0; rs++; end
        else rd_ready_a = 1'b1;
      end else rd_ready_a = 1'b0;
      if (rd_valid_a && rd_ready_a) begin if (ri < 2) rd_w_a[ri] = rd_data_a; ri++; end
    end
    wr_valid_a = 1'b0; rd_ready_a = 1'b0; start_a = 1'b0;
    rd_n_a = ri;
    lat_a = dc - hs - 1;
    if (dc < 0) begin
      miscompares++;
      $display("FAIL run_a_timeout: done not seen within 3000 cycles, required done pulse");
    end
  endtask

  task automatic run_b();
    int wi, ri, hs, dc;
    wi = 0; ri = 0; hs = -1; dc = -1;
    @(negedge clk); start_b = 1'b1; op_b = 2'b00;
    @(negedge clk); start_b = 1'b0;
    for (int cyc = 0; cyc < 3000 && dc < 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (done_b) dc = cyc;
      wr_valid_b = wr_ready_b && (wi < 3);
      wr_data_b  = 4'hF;
      if (wr_valid_b && wr_ready_b) begin if (wi == 0) hs = cyc; wi++; end
      rd_ready_b = rd_valid_b;
      if (rd_valid_b && rd_ready_b) begin if (ri < 3) rd_w_b[ri] = rd_data_b; ri++; end
    end
    wr_valid_b = 1'b0; rd_ready_b = 1'b0;
    rd_n_b = ri;
    lat_b = dc - hs - 1;
    if (dc < 0) begin
      miscompares++;
      $display("FAIL run_b_timeout: done not seen within 3000 cycles, required done pulse");
    end
  endtask

  task automatic test_reset();
    logic [15:0] outs;
    rst_n = 1'b0;
    start_a = 0; op_a = 0; wr_data_a = 0; wr_valid_a = 0; rd_ready_a = 0; pre_a = 0;
    start_b = 0; op_b = 0; wr_data_b = 0; wr_valid_b = 0; rd_ready_b = 0; pre_b = 0;
    cap_src_a = 8'h00; pre_val_a = 8'h00; pre_val_b = 10'h000;
    preload_a(8'h3C);
    preload_b(10'h000);
    repeat (3) @(negedge clk);
    outs = {wr_ready_a, rd_data_a, rd_valid_a, busy_a, done_a, scan_in_a, phi_a, phi_bar_a, capture_a, update_a, 3'b000};
    vectors++;
    if (outs !== 16'h0000) begin miscompares++; $display("FAIL reset_outs_a: got %h required 0000", outs); end
    outs = {wr_ready_b, rd_data_b, rd_valid_b, busy_b, done_b, scan_in_b, phi_b, phi_bar_b, capture_b, update_b, 3'b000};
    vectors++;
    if (outs !== 16'h0000) begin miscompares++; $display("FAIL reset_outs_b: got %h required 0000", outs); end
    rst_n = 1'b1;
    @(negedge clk); start_a = 1'b1; op_a = 2'b00; wr_valid_a = 1'b1; wr_data_a = 4'hA;
    @(negedge clk); start_a = 1'b0;
    for (int i = 0; i < 50 && !phi_bar_a; i++) @(negedge clk);
    vectors++;
    if (phi_bar_a !== 1'b1) begin miscompares++; $display("FAIL reset_reach_phib: phi_bar=%b required 1", phi_bar_a); end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({phi_bar_a, busy_a, rd_valid_a, phi_a} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_async: phi_bar,busy,rd_valid,phi=%b required 0000",
               {phi_bar_a, busy_a, rd_valid_a, phi_a});
    end
    wr_valid_a = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_shift_basic();
    clear_mon();
    preload_a(8'h3C);
    run_a(2'b00, 4'hA, 4'h5, 0, 0, 1'b1);
    repeat (4) @(negedge clk);
    vectors++; if (bits_a !== 8'h5A) begin miscompares++; $display("FAIL t2_scan_in_bits: got %h required 5a", bits_a); end
    vectors++; if (shift_a != 8) begin miscompares++; $display("FAIL t2_phi_pulses: got %0d required 8", shift_a); end
    vectors++; if (phib_cnt_a != 8) begin miscompares++; $display("FAIL t2_phib_pulses: got %0d required 8", phib_cnt_a); end
    vectors++; if (cap_cnt_a != 0) begin miscompares++; $display("FAIL t2_no_capture: got %0d required 0", cap_cnt_a); end
    vectors++; if (rd_n_a != 2) begin miscompares++; $display("FAIL t2_rd_count: got %0d required 2", rd_n_a); end
    vectors++; if (rd_w_a[0] !== 4'hC) begin miscompares++; $display("FAIL t2_rd0: got %h required c", rd_w_a[0]); end
    vectors++; if (rd_w_a[1] !== 4'h3) begin miscompares++; $display("FAIL t2_rd1: got %h required 3", rd_w_a[1]); end
    vectors++; if (lat_a != 43) begin miscompares++; $display("FAIL t2_done_latency: got %0d required 43", lat_a); end
    vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL t2_start_while_busy: busy=%b required 0", busy_a); end
    vectors++; if (s_a !== 8'h5A) begin miscompares++; $display("FAIL t2_chain_contents: got %h required 5a", s_a); end
  endtask

  task automatic test_capture_update();
    clear_mon();
    cap_src_a = 8'hE7;
    run_a(2'b11, 4'hA, 4'h5, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    vectors++; if (cap_cnt_a != 1) begin miscompares++; $display("FAIL t3_capture_pairs: got %0d required 1", cap_cnt_a); end
    vectors++; if (shift_a != 8) begin miscompares++; $display("FAIL t3_phi_pulses: got %0d required 8", shift_a); end
    vectors++; if (phib_cnt_a != 9) begin miscompares++; $display("FAIL t3_phib_pulses: got %0d required 9", phib_cnt_a); end
    vectors++; if (rd_w_a[0] !== 4'h7) begin miscompares++; $display("FAIL t3_rd0: got %h required 7", rd_w_a[0]); end
    vectors++; if (rd_w_a[1] !== 4'hE) begin miscompares++; $display("FAIL t3_rd1: got %h required e", rd_w_a[1]); end
    vectors++; if (upd_cnt_a != 1) begin miscompares++; $display("FAIL t3_update_pulses: got %0d required 1", upd_cnt_a); end
    vectors++; if (upd_a !== 8'h5A) begin miscompares++; $display("FAIL t3_update_reg: got %h required 5a", upd_a); end
  endtask

  task automatic test_backpressure();
    clear_mon();
    preload_a(8'h3C);
    run_a(2'b00, 4'hA, 4'h5, 10, 7, 1'b0);
    repeat (2) @(negedge clk);
    vectors++; if (bits_a !== 8'h5A) begin miscompares++; $display("FAIL t4_scan_in_bits: got %h required 5a", bits_a); end
    vectors++; if (shift_a != 8 || phib_cnt_a != 8) begin
      miscompares++; $display("FAIL t4_pulses: phi=%0d phi_bar=%0d required 8 and 8", shift_a, phib_cnt_a);
    end
    vectors++; if (rd_w_a[0] !== 4'hC) begin miscompares++; $display("FAIL t4_rd0: got %h required c", rd_w_a[0]); end
    vectors++; if (rd_w_a[1] !== 4'h3) begin miscompares++; $display("FAIL t4_rd1: got %h required 3", rd_w_a[1]); end
    vectors++; if (lat_a != 60) begin miscompares++; $display("FAIL t4_done_latency: got %0d required 60", lat_a); end
  endtask

  task automatic test_partial_word();
    clear_mon();
    preload_b(10'h3FF);
    run_b();
    repeat (2) @(negedge clk);
    vectors++; if (phi_cnt_b != 10) begin miscompares++; $display("FAIL t5_phi_pulses: got %0d required 10", phi_cnt_b); end
    vectors++; if (phib_cnt_b != 10) begin miscompares++; $display("FAIL t5_phib_pulses: got %0d required 10", phib_cnt_b); end
    vectors++; if (rd_n_b != 3) begin miscompares++; $display("FAIL t5_rd_count: got %0d required 3", rd_n_b); end
    vectors++; if (rd_w_b[0] !== 4'hF || rd_w_b[1] !== 4'hF) begin
      miscompares++; $display("FAIL t5_rd01: got %h %h required f f", rd_w_b[0], rd_w_b[1]);
    end
    vectors++; if (rd_w_b[2] !== 4'h3) begin miscompares++; $display("FAIL t5_rd2_partial: got %h required 3", rd_w_b[2]); end
    vectors++; if (lat_b != 55) begin miscompares++; $display("FAIL t5_done_latency: got %0d required 55", lat_b); end
    vectors++; if (s_b !== 10'h3FF) begin miscompares++; $display("FAIL t5_chain_contents: got %h required 3ff", s_b); end
  endtask

  task automatic test_protocol();
    vectors++;
    if (viol_a != 0 || viol_b != 0) begin
      miscompares++;
      $display("FAIL t6_protocol: violations a=%0d b=%0d required 0 and 0", viol_a, viol_b);
    end
  endtask

  initial begin
    test_reset();
    test_shift_basic();
    test_capture_update();
    test_backpressure();
    test_partial_word();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
